// File: rtl/conv5x5_pe.sv
// rtl/conv5x5_pe.sv - 5x5 convolution PE: serial weight/bias load, 4-stage MAC pipeline,
// ReLU with saturation to pixel range, and an output frame counter.
module conv5x5_pe #(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int ACC_BW = 24,
  parameter int SHIFT  = 7,
  parameter int OX     = 24,
  parameter int OY     = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_w_clear,
  input  logic                         i_w_valid,
  input  logic signed [W_BW-1:0]       i_w_data,
  input  logic signed [B_BW-1:0]       i_bias,
  input  logic                         i_in_valid,
  input  logic [KX*KY*I_F_BW-1:0]      i_window,
  output logic                         o_w_loaded,
  output logic                         o_out_valid,
  output logic [I_F_BW-1:0]            o_out_pixel,
  output logic                         o_frame_done,
  output logic                         o_drop
);

  localparam int NW     = KX * KY;
  localparam int P_BW   = I_F_BW + W_BW + 1;
  localparam int NOUT   = OX * OY;
  localparam int CNT_BW = $clog2(NOUT);
  localparam int K_BW   = $clog2(NW);
  localparam logic signed [ACC_BW-1:0] PIX_MAX = ACC_BW'((1 << I_F_BW) - 1);

  logic signed [W_BW-1:0]   r_w [NW];
  logic signed [B_BW-1:0]   r_bias;
  logic [K_BW-1:0]          r_k;
  logic                     r_loaded;

  logic                     r_v1, r_v2, r_v3;
  logic signed [P_BW-1:0]   r_prod [NW];
  logic signed [B_BW-1:0]   r_b1, r_b2;
  logic signed [ACC_BW-1:0] r_row [KY];
  logic signed [ACC_BW-1:0] r_acc;

  logic                     r_out_valid;
  logic [I_F_BW-1:0]        r_pix;
  logic                     r_frame_done;
  logic                     r_drop;
  logic [CNT_BW-1:0]        r_cnt;

  logic                     w_accept;
  logic signed [P_BW-1:0]   w_prod [NW];
  logic signed [ACC_BW-1:0] w_row [KY];
  logic signed [ACC_BW-1:0] w_sum;
  logic signed [ACC_BW-1:0] w_shift;
  logic [I_F_BW-1:0]        w_pix;

  assign w_accept = i_in_valid & r_loaded;

  // Clear has priority over a coincident weight word, which is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NW; i++) r_w[i] <= '0;
      r_bias   <= '0;
      r_k      <= '0;
      r_loaded <= 1'b0;
    end else if (i_w_clear) begin
      r_loaded <= 1'b0;
      r_k      <= '0;
    end else if (i_w_valid && !r_loaded) begin
      r_w[r_k] <= i_w_data;
      if (r_k == K_BW'(NW - 1)) begin
        r_bias   <= i_bias;
        r_loaded <= 1'b1;
        r_k      <= '0;
      end else begin
        r_k <= r_k + K_BW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      w_prod[i] = P_BW'($signed({1'b0, i_window[i*I_F_BW +: I_F_BW]})) * P_BW'(r_w[i]);
    end
  end

  always_comb begin
    for (int y = 0; y < KY; y++) begin
      w_row[y] = '0;
      for (int x = 0; x < KX; x++) begin
        w_row[y] = w_row[y] + ACC_BW'(r_prod[y*KX + x]);
      end
    end
  end

  always_comb begin
    w_sum = ACC_BW'(r_b2);
    for (int y = 0; y < KY; y++) w_sum = w_sum + r_row[y];
  end

  assign w_shift = r_acc >>> SHIFT;

  always_comb begin
    if (w_shift[ACC_BW-1])      w_pix = '0;
    else if (w_shift > PIX_MAX) w_pix = PIX_MAX[I_F_BW-1:0];
    else                        w_pix = w_shift[I_F_BW-1:0];
  end

  // Bias travels with each window so a reload mid-flight cannot mix weight sets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      for (int i = 0; i < NW; i++) r_prod[i] <= '0;
      for (int y = 0; y < KY; y++) r_row[y] <= '0;
      r_b1  <= '0;
      r_b2  <= '0;
      r_acc <= '0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (w_accept) begin
        r_prod <= w_prod;
        r_b1   <= r_bias;
      end
      if (r_v1) begin
        r_row <= w_row;
        r_b2  <= r_b1;
      end
      if (r_v2) r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_pix        <= '0;
      r_frame_done <= 1'b0;
      r_drop       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_out_valid  <= r_v3;
      r_frame_done <= r_v3 && (r_cnt == CNT_BW'(NOUT - 1));
      r_drop       <= i_in_valid && !r_loaded;
      if (r_v3) begin
        r_pix <= w_pix;
        r_cnt <= (r_cnt == CNT_BW'(NOUT - 1)) ? '0 : r_cnt + CNT_BW'(1);
      end
    end
  end

  assign o_w_loaded   = r_loaded;
  assign o_out_valid  = r_out_valid;
  assign o_out_pixel  = r_pix;
  assign o_frame_done = r_frame_done;
  assign o_drop       = r_drop;

endmodule

// File: tb/tb_conv5x5_pe.sv
// tb/tb_conv5x5_pe.sv - directed bench for conv5x5_pe; two instances share stimulus,
// one with SHIFT=0 and one with SHIFT=7.
module tb_conv5x5_pe;

  logic                clk;
  logic                reset_n;
  logic                w_clear;
  logic                w_valid;
  logic signed [7:0]   w_data;
  logic signed [15:0]  bias_in;
  logic                in_valid;
  logic [199:0]        window;

  logic                o0_w_loaded, o0_out_valid, o0_frame_done, o0_drop;
  logic [7:0]          o0_out_pixel;
  logic                o7_w_loaded, o7_out_valid, o7_frame_done, o7_drop;
  logic [7:0]          o7_out_pixel;

  logic signed [7:0]   wts [25];
  int                  n_cmp = 0;
  int                  n_bad = 0;

  conv5x5_pe #(.SHIFT(0)) dut_s0 (
    .clk(clk), .reset_n(reset_n), .i_w_clear(w_clear), .i_w_valid(w_valid),
    .i_w_data(w_data), .i_bias(bias_in), .i_in_valid(in_valid), .i_window(window),
    .o_w_loaded(o0_w_loaded), .o_out_valid(o0_out_valid), .o_out_pixel(o0_out_pixel),
    .o_frame_done(o0_frame_done), .o_drop(o0_drop)
  );

  conv5x5_pe #(.SHIFT(7)) dut_s7 (
    .clk(clk), .reset_n(reset_n), .i_w_clear(w_clear), .i_w_valid(w_valid),
    .i_w_data(w_data), .i_bias(bias_in), .i_in_valid(in_valid), .i_window(window),
    .o_w_loaded(o7_w_loaded), .o_out_valid(o7_out_valid), .o_out_pixel(o7_out_pixel),
    .o_frame_done(o7_frame_done), .o_drop(o7_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_window(input logic [7:0] p, input logic [7:0] c);
    for (int i = 0; i < 25; i++) window[i*8 +: 8] = p;
    window[12*8 +: 8] = c;
  endtask

  task automatic fill_weights(input logic signed [7:0] v);
    for (int i = 0; i < 25; i++) wts[i] = v;
  endtask

  task automatic load_weights();
    for (int k = 0; k < 25; k++) begin
      w_valid = 1'b1;
      w_data  = wts[k];
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    w_clear = 1'b1;
    tick();
    w_clear = 1'b0;
  endtask

  task automatic run_window(input string tag, input logic [7:0] p, input logic [7:0] c,
                            input logic [7:0] e0, input logic [7:0] e7);
    int lat;
    logic [7:0] got0, got7;
    lat  = 0;
    got0 = 8'hxx;
    got7 = 8'hxx;
    set_window(p, c);
    in_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      in_valid = 1'b0;
      if (lat == 0 && o0_out_valid === 1'b1) begin
        lat  = n;
        got0 = o0_out_pixel;
        got7 = o7_out_pixel;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_s0"}, {24'd0, got0}, {24'd0, e0});
    check({tag, "_s7"}, {24'd0, got7}, {24'd0, e7});
  endtask

  initial begin
    int n_valid, n_done, done_last, pix_bad, gap, idx, seen;

    reset_n  = 1'b0;
    w_clear  = 1'b0;
    w_valid  = 1'b0;
    w_data   = '0;
    bias_in  = '0;
    in_valid = 1'b0;
    window   = '0;
    tick();
    tick();
    check("reset_state", {12'd0, o0_w_loaded, o0_out_valid, o0_frame_done, o0_drop,
                          o0_out_pixel, o7_out_pixel}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Window before any weights are loaded is dropped.
    set_window(8'd10, 8'd10);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("drop_pulse", o0_drop, 1);
    tick();
    check("drop_one_cycle", o0_drop, 0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (o0_out_valid !== 1'b0) seen++;
    end
    check("drop_no_valid", seen, 0);

    fill_weights(8'sd1);
    bias_in = 16'sd0;
    load_weights();
    check("loaded_ones", o0_w_loaded, 1);
    w_valid = 1'b1;
    w_data  = 8'sd100;
    tick();
    w_valid = 1'b0;
    check("extra_word_ignored_loaded", o0_w_loaded, 1);
    run_window("ones_pix10", 8'd10, 8'd10, 8'd250, 8'd1);
    run_window("ones_pix255", 8'd255, 8'd255, 8'd255, 8'd49);
    check("hold_valid_low", o0_out_valid, 0);
    check("hold_pixel", o0_out_pixel, 255);

    pulse_clear();
    check("clear_unloads", o0_w_loaded, 0);
    fill_weights(8'sd0);
    wts[12] = 8'sd1;
    bias_in = -16'sd5;
    load_weights();
    check("loaded_centre", o0_w_loaded, 1);
    run_window("relu_centre3", 8'd50, 8'd3, 8'd0, 8'd0);
    run_window("centre200", 8'd50, 8'd200, 8'd195, 8'd1);

    // Clear coinciding with the 25th word wins.
    pulse_clear();
    fill_weights(8'sd127);
    bias_in = 16'sd0;
    for (int k = 0; k < 24; k++) begin
      w_valid = 1'b1;
      w_data  = wts[k];
      tick();
    end
    w_valid = 1'b1;
    w_clear = 1'b1;
    tick();
    w_valid = 1'b0;
    w_clear = 1'b0;
    check("clear_at_k24", o0_w_loaded, 0);
    tick();
    check("clear_at_k24_stays", o0_w_loaded, 0);
    load_weights();
    check("reload_after_clear", o0_w_loaded, 1);
    run_window("saturate", 8'd255, 8'd255, 8'd255, 8'd255);

    pulse_clear();
    fill_weights(-8'sd1);
    bias_in = 16'sd300;
    load_weights();
    run_window("neg_weights", 8'd10, 8'd10, 8'd50, 8'd0);

    // Full frame of back-to-back windows from a clean counter.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    fill_weights(8'sd1);
    bias_in = 16'sd0;
    load_weights();
    n_valid = 0; n_done = 0; done_last = 0; pix_bad = 0; gap = 0;
    for (int c = 0; c < 584; c++) begin
      if (c < 576) begin
        set_window(8'(c % 11), 8'(c % 11));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      idx = c - 3;
      if (o0_frame_done === 1'b1) begin
        n_done++;
        if (idx == 575 && o0_out_valid === 1'b1) done_last = 1;
      end
      if (o0_out_valid === 1'b1) begin
        n_valid++;
        if (idx < 0 || o0_out_pixel !== 8'(25 * (idx % 11))) pix_bad++;
      end else if (c >= 3 && c < 579) begin
        gap++;
      end
    end
    check("frame_valid_count", n_valid, 576);
    check("frame_no_gaps", gap, 0);
    check("frame_pixels", pix_bad, 0);
    check("frame_done_count", n_done, 1);
    check("frame_done_on_last", done_last, 1);

    // Reset in the middle of the next frame.
    for (int c = 0; c < 300; c++) begin
      set_window(8'(c % 11), 8'(c % 11));
      in_valid = 1'b1;
      tick();
    end
    check("pre_reset_valid", o0_out_valid, 1);
    check("pre_reset_pixel", o0_out_pixel, 250);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_reset_outputs", {12'd0, o0_w_loaded, o0_out_valid, o0_frame_done, o0_drop,
                                  o0_out_pixel, o7_out_pixel}, 32'd0);
    tick();
    check("reset_outputs_next", {12'd0, o0_w_loaded, o0_out_valid, o0_frame_done, o0_drop,
                                 o0_out_pixel, o7_out_pixel}, 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_reset_drop", o0_drop, 1);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (o0_out_valid !== 1'b0 || o7_out_valid !== 1'b0) seen++;
    end
    check("post_reset_no_valid", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
